// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: the FuncCode map the decoder relies on
// and the control FSM state encoding.
package alu_pkg;

  localparam logic [3:0] FC_ADD   = 4'd0;
  localparam logic [3:0] FC_SUB   = 4'd1;
  localparam logic [3:0] FC_PASSA = 4'd2;
  localparam logic [3:0] FC_NOT   = 4'd3;
  localparam logic [3:0] FC_AND   = 4'd4;
  localparam logic [3:0] FC_OR    = 4'd5;
  localparam logic [3:0] FC_NE    = 4'd6;
  localparam logic [3:0] FC_EQ    = 4'd7;
  localparam logic [3:0] FC_GTZ   = 4'd8;
  localparam logic [3:0] FC_LTZ   = 4'd9;
  localparam logic [3:0] FC_PASSB = 4'd10;
  localparam logic [3:0] FC_MUL   = 4'd11;
  localparam logic [3:0] FC_SHL   = 4'd12;
  localparam logic [3:0] FC_SHR   = 4'd13;
  localparam logic [3:0] FC_NEG   = 4'd14;
  localparam logic [3:0] FC_ZERO  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] fc);
    return (fc == FC_SHL) || (fc == FC_SHR);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result bus of the multicycle ALU. The master is the issuing pipeline stage,
// the slave is the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  import alu_pkg::*;

  // Both sides use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; once raised, out_valid and its payload stay put until taken.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FuncCode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             BCond;
  logic             Ov;
  logic             busy;
  state_e           dbg_state;

  modport master (
    output in_valid, A, B, FuncCode, out_ready,
    input  in_ready, out_valid, C, BCond, Ov, busy, dbg_state
  );

  modport slave (
    input  in_valid, A, B, FuncCode, out_ready,
    output in_ready, out_valid, C, BCond, Ov, busy, dbg_state
  );

endinterface

// File: rtl/alu_iter_unit.sv
// Iteration engine for the multi-cycle ops: one-bit-per-cycle arithmetic shifts and
// a shift-add unsigned multiply. Outputs present the value after the current step.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ov_o
);

  localparam int CW = SHW + 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    op_d    = op_q;
    addend  = lo_q[0] ? mcand_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    if (start_i) begin
      op_d    = op_i;
      ov_d    = 1'b0;
      hi_d    = '0;
      lo_d    = (op_i == FC_MUL) ? b_i : a_i;
      mcand_d = a_i;
      cnt_d   = (op_i == FC_MUL) ? CW'(WIDTH) : CW'(b_i[SHW-1:0]);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      case (op_q)
        // Multiplier sits in lo and drains out the bottom as the product fills in.
        FC_MUL: {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        FC_SHL: begin
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
          ov_d = ov_q | (lo_q[WIDTH-1] ^ lo_q[WIDTH-2]);
        end
        default: lo_d = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      op_q    <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      op_q    <= op_d;
    end
  end

  assign done_o   = (cnt_q == CW'(1));
  assign result_o = lo_d;
  assign ov_o     = (op_q == FC_MUL) ? (|hi_d) : ov_d;

endmodule

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU with valid/ready handshake; single-cycle ops are computed
// here, shifts and multiply are delegated to alu_iter_unit.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             reset,
  alu_multicycle_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             bcond_q, bcond_d;
  logic             ov_q, ov_d;
  logic             in_ready;
  logic             accept;
  logic             goes_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic             iter_ov;

  // Packs {C, BCond, Ov}.
  function automatic logic [WIDTH+1:0] single_op(input logic [3:0] fc,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] c;
    logic             bc;
    logic             ov;
    c  = '0;
    bc = 1'b0;
    ov = 1'b0;
    case (fc)
      FC_ADD: begin
        c  = a + b;
        ov = (a[WIDTH-1] == b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
      end
      FC_SUB: begin
        c  = a - b;
        ov = (a[WIDTH-1] != b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
      end
      FC_PASSA:       c = a;
      FC_NOT:         c = ~a;
      FC_AND:         c = a & b;
      FC_OR:          c = a | b;
      FC_NE:          begin c = a; bc = (a != b); end
      FC_EQ:          begin c = a; bc = (a == b); end
      FC_GTZ:         begin c = a; bc = !a[WIDTH-1] && (a != '0); end
      FC_LTZ:         begin c = a; bc = a[WIDTH-1]; end
      FC_PASSB:       c = b;
      FC_SHL, FC_SHR: c = a;
      FC_NEG: begin
        c  = -a;
        ov = (a == MIN_NEG);
      end
      default: ;
    endcase
    return {c, bc, ov};
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  // Zero-distance shifts complete like a single-cycle op.
  assign goes_iter = (bus.FuncCode == FC_MUL) ||
                     (is_shift(bus.FuncCode) && (bus.B[SHW-1:0] != '0));

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    bcond_d    = bcond_q;
    ov_d       = ov_q;
    iter_start = 1'b0;
    case (state_q)
      ITER: begin
        if (iter_done) begin
          state_d = DONE;
          c_d     = iter_result;
          bcond_d = 1'b0;
          ov_d    = iter_ov;
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          if (goes_iter) begin
            state_d    = ITER;
            iter_start = 1'b1;
          end else begin
            state_d                = DONE;
            {c_d, bcond_d, ov_d}   = single_op(bus.FuncCode, bus.A, bus.B);
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      bcond_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      bcond_q <= bcond_d;
      ov_q    <= ov_d;
    end
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (iter_start),
    .op_i     (bus.FuncCode),
    .a_i      (bus.A),
    .b_i      (bus.B),
    .done_o   (iter_done),
    .result_o (iter_result),
    .ov_o     (iter_ov)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ITER);
  assign bus.C         = c_q;
  assign bus.BCond     = bcond_q;
  assign bus.Ov        = ov_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed plus light random bench for alu_multicycle at WIDTH=16, with a result
// scoreboard fed at issue time and drained when results are handed over.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed no response expected one within bound", tag);
  endtask

  // Reference model, {C, BCond, Ov}, written in integer arithmetic.
  function automatic logic [W+1:0] model(input logic [3:0] fc, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int sa, sb, r, n;
    logic [2*W-1:0] p;
    logic [W-1:0] c, back;
    logic bc, ov;
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b[3:0]);
    c  = '0;
    bc = 1'b0;
    ov = 1'b0;
    case (fc)
      4'd0:  begin r = sa + sb; c = r[W-1:0]; ov = (r > 32767) || (r < -32768); end
      4'd1:  begin r = sa - sb; c = r[W-1:0]; ov = (r > 32767) || (r < -32768); end
      4'd2:  c = a;
      4'd3:  c = ~a;
      4'd4:  c = a & b;
      4'd5:  c = a | b;
      4'd6:  begin c = a; bc = (a != b); end
      4'd7:  begin c = a; bc = (a == b); end
      4'd8:  begin c = a; bc = (sa > 0); end
      4'd9:  begin c = a; bc = (sa < 0); end
      4'd10: c = b;
      4'd11: begin p = {16'h0, a} * {16'h0, b}; c = p[W-1:0]; ov = (p[2*W-1:W] != 0); end
      4'd12: begin
        c    = a << n;
        back = W'($signed(c) >>> n);
        ov   = (back != a);
      end
      4'd13: c = W'($signed(a) >>> n);
      4'd14: begin r = -sa; c = r[W-1:0]; ov = (r > 32767); end
      default: c = '0;
    endcase
    return {c, bc, ov};
  endfunction

  function automatic int exp_lat(input logic [3:0] fc, input logic [W-1:0] b);
    if (fc == 4'd11) return W + 1;
    if (fc == 4'd12 || fc == 4'd13) return int'(b[3:0]) + 1;
    return 1;
  endfunction

  // Called just after a rising edge; returns at the falling edge where out_valid is seen.
  task automatic send(input logic [3:0] fc, input logic [W-1:0] a, input logic [W-1:0] b,
                      input string tag, output int waits);
    int lat, busy_cnt;
    bus.in_valid = 1'b1;
    bus.FuncCode = fc;
    bus.A        = a;
    bus.B        = b;
    waits        = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.in_ready && waits < 200);
    if (!bus.in_ready) begin
      timeout({tag, " accept"});
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(fc, a, b));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A        = W'($urandom);
      bus.B        = W'($urandom);
      bus.FuncCode = 4'($urandom);
      lat      = 0;
      busy_cnt = 0;
      do begin
        @(negedge clk);
        lat++;
        if (!bus.out_valid && bus.busy === 1'b1) busy_cnt++;
      end while (!bus.out_valid && lat < 200);
      if (!bus.out_valid) timeout({tag, " result"});
      else begin
        check({tag, " latency"}, lat, exp_lat(fc, b));
        check({tag, " busy cycles"}, busy_cnt, exp_lat(fc, b) - 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_result: observed C=%0h expected no result", bus.C);
      end else begin
        mon_e = exp_q.pop_front();
        check("result {C,BCond,Ov}", {14'h0, bus.C, bus.BCond, bus.Ov}, {14'h0, mon_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected one within 200us");
    $fatal(1);
  end

  initial begin
    int waits;
    logic [3:0]   rfc;
    logic [W-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.FuncCode  = '0;
    bus.out_ready = 1'b1;

    // Clock and reset
    repeat (2) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset C", bus.C, 0);
    check("reset BCond/Ov", {bus.BCond, bus.Ov}, 0);
    check("reset state", bus.dbg_state, IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed single-cycle and iterative ops
    send(4'd0,  16'h7FFF, 16'h0001, "add overflow", waits);
    @(posedge clk); #1;
    send(4'd1,  16'd5, 16'd7, "sub negative", waits);
    @(posedge clk); #1;
    send(4'd11, 16'd300, 16'd300, "mul 300x300", waits);
    @(posedge clk); #1;
    send(4'd11, 16'd12, 16'd11, "mul 12x11", waits);
    @(posedge clk); #1;
    send(4'd13, 16'h8000, 16'd4, "shr 8000>>>4", waits);
    @(posedge clk); #1;
    send(4'd12, 16'h4001, 16'd1, "shl 4001<<<1", waits);
    @(posedge clk); #1;
    send(4'd12, 16'h1234, 16'hFFF0, "shl by 0", waits);
    @(posedge clk); #1;
    send(4'd8,  16'h0000, 16'd0, "gtz 0", waits);
    @(posedge clk); #1;
    send(4'd8,  16'h0001, 16'd0, "gtz 1", waits);
    @(posedge clk); #1;
    send(4'd8,  16'hFFFF, 16'd0, "gtz -1", waits);
    @(posedge clk); #1;
    send(4'd14, 16'h8000, 16'd0, "neg min", waits);
    @(posedge clk); #1;

    // Random mix over every code
    for (int i = 0; i < 16; i++) begin
      rfc = 4'($urandom_range(0, 15));
      ra  = W'($urandom);
      rb  = W'($urandom);
      send(rfc, ra, rb, "random", waits);
      @(posedge clk); #1;
    end

    // Backpressure: result must hold while the consumer stalls
    bus.out_ready = 1'b0;
    send(4'd4, 16'hF0F0, 16'hFF00, "and stalled", waits);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall out_valid", bus.out_valid, 1);
      check("stall in_ready", bus.in_ready, 0);
      check("stall C", bus.C, 16'hF000);
      check("stall BCond/Ov", {bus.BCond, bus.Ov}, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(4'd7, 16'd9, 16'd9, "eq after stall", waits);
    check("eq after stall accept wait", waits, 1);

    // Asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.FuncCode = 4'd11;
    bus.A        = 16'd300;
    bus.B        = 16'd300;
    @(negedge clk);
    check("abort mul in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("abort mul busy before reset", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("abort out_valid", bus.out_valid, 0);
    check("abort busy", bus.busy, 0);
    check("abort C", bus.C, 0);
    check("abort Ov", bus.Ov, 0);
    check("abort state", bus.dbg_state, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("after abort in_ready", bus.in_ready, 1);
    check("after abort out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    send(4'd0, 16'd100, 16'd23, "add after abort", waits);

    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor of the 16-bit combinational ALU. It keeps the same 4-bit FuncCode map, which the CPU decoder relies on.
- Adds a valid/ready handshake, an overflow flag, and three iterative ops:
  - variable arithmetic left shift
  - variable arithmetic right shift
  - unsigned multiply, in the formerly empty code 11
- Sits in the EX stage. The hazard unit stalls the pipeline on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (at least 4, power of two).
- SHW, $clog2(WIDTH), number of bits of B used as shift amount.

Ports:
- clk       input   1      clock; all state updates on the rising edge
- reset     input   1      asynchronous, active-high reset
- in_valid  input   1      A/B/FuncCode valid this cycle
- in_ready  output  1      block accepts an operation this cycle
- A         input   WIDTH  operand A
- B         input   WIDTH  operand B; shift amount taken from B[SHW-1:0]
- FuncCode  input   4      operation select
- out_valid output  1      C/BCond/Ov hold a valid result
- out_ready input   1      consumer takes the result this cycle
- C         output  WIDTH  result
- BCond     output  1      branch condition
- Ov        output  1      overflow flag
- busy      output  1      iterative op in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE; C=0, BCond=0, Ov=0, out_valid=0, busy=0; all iteration registers=0.
- Reset asserted mid-operation aborts the operation. No result is produced.
- Accept: an operation is accepted when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
- Output handshake: a result is consumed when out_valid && out_ready. While out_valid && !out_ready, C/BCond/Ov are held stable and in_ready=0.
- States:
  - IDLE: accept a single-cycle op -> DONE. Accept an iterative op -> ITER.
  - ITER: iterate; when the count reaches 0 -> DONE. busy=1.
  - DONE: out_valid=1.
    - out_ready with no new accept -> IDLE.
    - out_ready with a new accept -> DONE or ITER, per the new op.
- Single-cycle ops: result is registered; out_valid is asserted the cycle after accept (latency 1). Codes:
  - 0: A+B; Ov = signed overflow.
  - 1: A-B (two's complement); Ov = signed overflow.
  - 2: A.
  - 3: ~A.
  - 4: A&B.
  - 5: A|B.
  - 6: C=A, BCond=(A!=B).
  - 7: C=A, BCond=(A==B).
  - 8: C=A, BCond=(A signed >0).
  - 9: C=A, BCond=A[WIDTH-1].
  - 10: B.
  - 14: -A (two's complement); Ov=1 iff A is the minimum negative value.
  - 15: 0.
  - BCond=0 and Ov=0 wherever not stated.
- Iterative ops:
  - 12: A<<<n, n=B[SHW-1:0]. One bit per ITER cycle.
    - Ov=1 if any shifted-out bit differs from the result sign bit.
    - n=0 goes straight to DONE: latency 1, C=A.
  - 13: A>>>n, sign-fill, one bit per ITER cycle; Ov=0. n=0 as for code 12.
  - Latency for codes 12/13 is n+1 cycles from accept to out_valid.
  - 11: unsigned shift-add multiply, one multiplier bit per cycle, WIDTH iterations.
    - C = low WIDTH bits of the product.
    - Ov=1 iff the high WIDTH bits are nonzero.
    - Latency WIDTH+1.
- Operands and FuncCode are captured at accept. Input changes during ITER have no effect.
- All arithmetic is modulo 2^WIDTH.
- in_valid during ITER is ignored (in_ready=0). No queueing.

Decomposition:
- Package alu_pkg holds:
  - FuncCode constants FC_ADD=0 … FC_ZERO=15, with FC_MUL=11, FC_SHL=12, FC_SHR=13.
  - State encoding IDLE/ITER/DONE.
- Single-cycle datapath is one combinational function inside the module.
- One natural sub-module, alu_iter_unit: the shift/multiply iteration registers and counter, with start/done signals. The parent owns the FSM and the handshake.

Test Plan:
- WIDTH=16: FuncCode=0, A=16'h7FFF, B=1 -> C=16'h8000, Ov=1, out_valid one cycle after accept. FuncCode=1, A=5, B=7 -> C=16'hFFFE, Ov=0.
- FuncCode=11, A=300, B=300 -> C=16'h5F90 (90000 mod 65536), Ov=1, out_valid exactly 17 cycles after accept, busy=1 throughout ITER. A=12, B=11 -> C=132, Ov=0.
- FuncCode=13, A=16'h8000, B=4 -> C=16'hF800 after 5 cycles. FuncCode=12, A=16'h4001, B=1 -> C=16'h8002, Ov=1. B=0 -> C=A, latency 1.
- Backpressure: hold out_ready=0 for 3 cycles after a result -> C/BCond/Ov stable, in_ready=0. Then out_ready=1 with in_valid=1 (FuncCode=7, A=B=9) -> new op accepted the same cycle; next cycle BCond=1, C=9.
- Assert reset asynchronously mid-multiply (cycle 5 of ITER) -> out_valid, busy, C, Ov all 0 immediately. After release, in_ready=1 and no stale result appears.
- FuncCode=8 with A=0, A=1, A=16'hFFFF -> BCond=0, 1, 0. FuncCode=14, A=16'h8000 -> C=16'h8000, Ov=1.
